// File: rtl/btn_conditioner.sv
// Push-button synchroniser, debouncer and press/release strobe generator.
// Defining AUTO_REPEAT_EN adds periodic press strobes while a button is held.
module btn_conditioner #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int RPT_W           = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_db,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifndef SYNTHESIS
    // Parameter legality check at simulation start
    initial begin
        if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > ((2 ** CNT_W) - 1))) begin
            $error("btn_conditioner: DEBOUNCE_CYCLES=%0d outside 2..2^CNT_W-1", DEBOUNCE_CYCLES);
        end
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic             r_sync1;
        logic             r_sync2;
        logic             r_db;
        logic             r_press;
        logic             r_release;
        logic [CNT_W-1:0] r_cnt;
        logic             w_diff;
        logic             w_done;
        logic             w_rise;
        logic             w_fall;
        logic             w_rpt;

        assign w_diff = (r_sync2 != r_db);
        assign w_done = w_diff && (r_cnt == DB_MAX);
        assign w_rise = w_done && r_sync2;
        assign w_fall = w_done && !r_sync2;

`ifdef AUTO_REPEAT_EN
        localparam logic [RPT_W-1:0] RPT_MAX    = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
        logic [RPT_W-1:0] r_rpt;

        // A release edge suppresses any repeat strobe that would land on it
        assign w_rpt = r_db && !w_fall && (r_rpt == RPT_MAX);

        // Hold-time counter; reloading keeps later strobes REPEAT_PERIOD apart
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_rpt <= '0;
            end else if (!r_db || w_fall) begin
                r_rpt <= '0;
            end else if (w_rpt) begin
                r_rpt <= RPT_RELOAD;
            end else begin
                r_rpt <= r_rpt + RPT_W'(1);
            end
        end
`else
        assign w_rpt = 1'b0;
`endif

        // Two-flop synchroniser, debounce counter and registered strobes
        always_ff @(posedge clock) begin
            if (!reset) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_db      <= 1'b0;
                r_cnt     <= '0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_sync1 <= btn_raw[i];
                r_sync2 <= r_sync1;
                if (!w_diff) begin
                    r_cnt <= '0;
                end else if (w_done) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_press   <= w_rise || w_rpt;
                r_release <= w_fall;
            end
        end

        assign btn_db[i]      = r_db;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with a short debounce window.
// Inputs change on the falling edge; outputs are sampled one full cycle later.
module tb_btn_conditioner;

    localparam int WIDTH = 2;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] btn_raw;
    logic [WIDTH-1:0] btn_db;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;

    int checks   = 0;
    int failures = 0;

    btn_conditioner #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .RPT_W          (5)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_db     (btn_db),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic       rst_n;
        logic [1:0] raw;
        logic [1:0] db;
        logic [1:0] press;
        logic [1:0] rel;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic rst_n, input logic [1:0] raw,
                       input logic [1:0] db, input logic [1:0] press, input logic [1:0] rel);
        vec_t v;
        v.rst_n = rst_n;
        v.raw   = raw;
        v.db    = db;
        v.press = press;
        v.rel   = rel;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clock edge with the given inputs, then settle to the falling edge
    task automatic step(input logic rst_n, input logic [1:0] raw);
        reset   = rst_n;
        btn_raw = raw;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 2'b11;

        // Reset held with both pins high
        add(3, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
        // Clean press of bit 0: rises on the 6th edge
        add(5, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00);
        add(1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00);
        add(1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        // Bit 1 high for 3 cycles only: rejected
        add(3, 1'b1, 2'b11, 2'b01, 2'b00, 2'b00);
        add(4, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        // 3 high, 1-cycle gap, then held: rises 6 edges after the gap
        add(3, 1'b1, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        add(5, 1'b1, 2'b11, 2'b01, 2'b00, 2'b00);
        add(1, 1'b1, 2'b11, 2'b11, 2'b10, 2'b00);
        add(1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
        // Release bit 1, then bit 0
        add(5, 1'b1, 2'b01, 2'b11, 2'b00, 2'b00);
        add(1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b10);
        add(5, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00);
        add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01);
        add(1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst_n, vecs[i].raw);
            check($sformatf("vec%0d_db", i), btn_db, vecs[i].db);
            check($sformatf("vec%0d_press", i), btn_press, vecs[i].press);
            check($sformatf("vec%0d_release", i), btn_release, vecs[i].rel);
        end

        // Reset asserted on the 4th edge of a held press discards the count
        for (int e = 1; e <= 11; e++) begin
            step((e == 4) ? 1'b0 : 1'b1, 2'b01);
            check($sformatf("rstmid_e%0d_db", e), btn_db, (e >= 10) ? 2'b01 : 2'b00);
            check($sformatf("rstmid_e%0d_press", e), btn_press, (e == 10) ? 2'b01 : 2'b00);
            check($sformatf("rstmid_e%0d_release", e), btn_release, 2'b00);
        end
        for (int e = 1; e <= 8; e++) step(1'b1, 2'b00);
        check("rstmid_idle_db", btn_db, 2'b00);

        // Hold bit 0 for 30 cycles; press edge P is the 6th edge
        for (int e = 1; e <= 40; e++) begin
            logic [1:0] exp_db;
            logic [1:0] exp_p;
            logic [1:0] exp_r;
            step(1'b1, (e <= 30) ? 2'b01 : 2'b00);
            exp_db = (e >= 6 && e <= 35) ? 2'b01 : 2'b00;
            exp_p  = (e == 6) ? 2'b01 : 2'b00;
`ifdef AUTO_REPEAT_EN
            if (e >= 16 && e <= 35 && ((e - 16) % 3) == 0) exp_p = 2'b01;
`endif
            exp_r  = (e == 36) ? 2'b01 : 2'b00;
            check($sformatf("hold_e%0d_db", e), btn_db, exp_db);
            check($sformatf("hold_e%0d_press", e), btn_press, exp_p);
            check($sformatf("hold_e%0d_release", e), btn_release, exp_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Upstream input stage for the pong video controller. It synchronises and debounces the raw push-button pins and drives the clean `btn[1:0]` bus that the paddle animation logic consumes.
- Also produces single-cycle press and release strobes for later game-control logic (serve, pause).
- Runs on the 100 MHz system clock, the same clock as the controller.

Parameters:
WIDTH, 2, number of independent buttons conditioned.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
CNT_W, 20, width of each debounce counter.
REPEAT_DELAY, 50000000, cycles from press to first auto-repeat strobe (used only with AUTO_REPEAT_EN).
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (used only with AUTO_REPEAT_EN).
RPT_W, 26, width of each repeat counter.

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-low reset.
btn_raw  input  WIDTH  asynchronous button pins, active-high.
btn_db  output  WIDTH  debounced level; feeds controller `btn`.
btn_press  output  WIDTH  one-cycle strobe on debounced rise (plus auto-repeat strobes when enabled).
btn_release  output  WIDTH  one-cycle strobe on debounced fall.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when `reset`==0 at a rising edge, all of the following are cleared:
  - synchroniser flops, counters;
  - `btn_db`, `btn_press`, `btn_release` (all outputs reset to 0).
- Each bit i is processed independently. There is no cross-bit interaction.
- Synchroniser: two flops in series, `sync1 <= btn_raw[i]` then `sync2 <= sync1`. Only `sync2` is used downstream.
- Debounce counter `cnt[i]` (CNT_W bits), evaluated each edge:
  - If `sync2 == btn_db[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_db[i] <= sync2`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- Latency: a clean input step seen at edge 1 changes `btn_db` on edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any return of `sync2` to the current `btn_db` value before the count completes restarts the count from 0. The counter never wraps.
- Strobes are registered and asserted on the same edge that `btn_db` changes:
  - 0→1 transition: `btn_press` = 1 for exactly one cycle.
  - 1→0 transition: `btn_release` = 1 for exactly one cycle.
  - `btn_press` and `btn_release` are never both high for the same bit.
- Reset mid-count: the count is discarded. After reset release, a held input needs the full DEBOUNCE_CYCLES+2 edges again; no strobe is emitted during or for the reset itself.
- Input already high at reset release: treated as a fresh press, so `btn_press` fires when `btn_db` rises.
- Illegal DEBOUNCE_CYCLES (<2 or ≥2^CNT_W) is flagged by a simulation-only `$error` in an initial block.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined: each bit gets a repeat counter `rpt[i]` (RPT_W bits).
  - Cleared whenever `btn_db[i]`==0 and on the press edge.
  - While `btn_db[i]`==1, `rpt` increments each cycle.
  - On reaching REPEAT_DELAY: `btn_press[i]` pulses one cycle and `rpt` reloads to REPEAT_DELAY-REPEAT_PERIOD, so later strobes occur every REPEAT_PERIOD cycles while held.
  - A release stops repeats immediately; no repeat strobe coincides with `btn_release`.
- Undefined: no repeat counters exist, and `btn_press` pulses only on the debounced rising edge.
- All other behaviour is identical with and without the macro.

Test Plan:
Use DEBOUNCE_CYCLES=4, CNT_W=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated.
1. Reset: hold `reset`=0 for 3 edges with `btn_raw`=2'b11 → `btn_db`=0, `btn_press`=0, `btn_release`=0 throughout.
2. Clean press: after reset, set `btn_raw[0]`=1 before edge 1 and hold → `btn_db[0]` rises at edge 6, `btn_press[0]`=1 only during cycle 6, bit 1 unaffected.
3. Glitch: `btn_raw[1]` high for 3 cycles then low → `btn_db[1]` stays 0, no strobes. Repeat with a 1-cycle low gap inside a 10-cycle high → `btn_db` rises 6 edges after the gap ends.
4. Release: from `btn_db`=2'b01, drop `btn_raw[0]` → `btn_db[0]` falls 6 edges later with a single `btn_release[0]` pulse.
5. Reset mid-count: raise `btn_raw[0]`, pull `reset` low at edge 4 for 1 edge, keep input high → no strobe near reset, `btn_db[0]` rises 6 edges after reset release.
6. AUTO_REPEAT_EN defined: hold `btn_raw[0]` for 30 cycles → `btn_press[0]` pulses at the press edge P, then P+10, P+13, P+16, …; none after release. With the macro undefined → only the P pulse.
